// File: rtl/data_memory_if.sv
// data_memory_if: MEM-stage bus plus console TX stream and error flag.
//   master : processor / consumer side (drives cmd/addr/din and tx_ready)
//   slave  : data_memory side (returns load data, TX stream, error flag)
interface data_memory_if;
    logic [31:0] MEM_mem_addr;
    logic [1:0]  MEM_mem_cmd;
    logic [31:0] MEM_mem_din;
    logic [31:0] DM_mem_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        DM_err;

    modport master (
        output MEM_mem_addr, MEM_mem_cmd, MEM_mem_din, tx_ready,
        input  DM_mem_dout, tx_data, tx_valid, DM_err
    );

    modport slave (
        input  MEM_mem_addr, MEM_mem_cmd, MEM_mem_din, tx_ready,
        output DM_mem_dout, tx_data, tx_valid, DM_err
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: MEM-stage data RAM plus MMIO window.
//   0x0000_0000.. : word RAM (DEPTH_WORDS x 32, combinational read)
//   0xFFFF_0000   : TXDATA  store pushes din[7:0] into the console FIFO
//   0xFFFF_0004   : STATUS  {count[10:8], bad[5], ovf[4], empty[1], full[0]}
//   0xFFFF_0008   : CYCLE   free-running counter, loadable by store
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - data_memory_if.slave (bus command, load data, TX stream, DM_err)
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int TX_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int TW = $clog2(TX_DEPTH);

    localparam logic [31:0] RAM_BYTES   = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0008;

    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    localparam logic [TW-1:0] PTR_ONE  = 1;
    localparam logic [TW:0]   CNT_ONE  = 1;
    localparam logic [TW:0]   CNT_FULL = (TW+1)'(TX_DEPTH);

    logic [31:0] addr, din;
    logic        is_load, is_store;
    logic        hit_ram, hit_tx, hit_st, hit_cyc, hit_bad;

    assign addr     = bus.MEM_mem_addr;
    assign din      = bus.MEM_mem_din;
    assign is_load  = (bus.MEM_mem_cmd == BUS_LOAD);
    assign is_store = (bus.MEM_mem_cmd == BUS_STORE);

    // MMIO addresses are aligned, so only the RAM check needs the explicit
    // alignment term; a misaligned address falls through to hit_bad.
    assign hit_ram = (addr[1:0] == 2'b00) && (addr < RAM_BYTES);
    assign hit_tx  = (addr == ADDR_TXDATA);
    assign hit_st  = (addr == ADDR_STATUS);
    assign hit_cyc = (addr == ADDR_CYCLE);
    assign hit_bad = !(hit_ram || hit_tx || hit_st || hit_cyc);

    // ---------------- state ----------------
    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo [TX_DEPTH];
    logic [TW-1:0] rd_ptr, wr_ptr;
    logic [TW:0]   count;
    logic [31:0]   cycle;
    logic          ovf, bad;

    logic full, empty, pop, push_req, push, ovf_set, bad_set, flag_clr;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = is_store && hit_tx;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && !push;
    assign bad_set  = (is_load || is_store) && hit_bad;
    assign flag_clr = is_load && hit_st;

    // ---------------- read path ----------------
    logic [31:0] status, rd_data;

    always_comb begin
        status       = '0;
        status[0]    = full;
        status[1]    = empty;
        status[4]    = ovf;
        status[5]    = bad;
        status[10:8] = 3'(count);
    end

    always_comb begin
        rd_data = '0;
        if (is_load) begin
            if (hit_ram)      rd_data = ram[addr[AW+1:2]];
            else if (hit_st)  rd_data = status;
            else if (hit_cyc) rd_data = cycle;
        end
    end

    assign bus.DM_mem_dout = rd_data;
    assign bus.tx_valid    = !empty;
    assign bus.tx_data     = fifo[rd_ptr];
    assign bus.DM_err      = ovf | bad;

    // ---------------- RAM (no reset) ----------------
    always_ff @(posedge clk) begin
        if (is_store && hit_ram)
            ram[addr[AW+1:2]] <= din;
    end

    // ---------------- TX FIFO ----------------
    // Storage is reset so an empty FIFO presents 0 on tx_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TX_DEPTH; i++)
                fifo[i] <= '0;
        end else if (push) begin
            fifo[wr_ptr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ---------------- cycle counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cycle <= '0;
        else if (is_store && hit_cyc)
            cycle <= din;
        else
            cycle <= cycle + 32'd1;
    end

    // ---------------- sticky flags ----------------
    // Set dominates clear; a STATUS load returns the pre-clear value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            bad <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~flag_clr);
            bad <= bad_set | (bad & ~flag_clr);
        end
    end
endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory subsystem attached to the processor's MEM-stage bus. Decodes `MEM_mem_cmd`/`MEM_mem_addr`/`MEM_mem_din` into a word-addressed data RAM and a small MMIO window:
- a byte-wide console transmit FIFO with a valid/ready output;
- a loadable free-running cycle counter;
- a status register with sticky error flags.

Load data returns combinationally on `DM_mem_dout` within the same cycle, because the processor captures it into MEM/WB at the end of the MEM cycle.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words (power of two).
- `TX_DEPTH`, 4: console FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low. Asserting it (low) clears all state immediately.
- `MEM_mem_addr`  in  32  byte address.
- `MEM_mem_cmd`  in  2  bus command: `BUS_NONE`=2'b00, `BUS_LOAD`=2'b01, `BUS_STORE`=2'b10. 2'b11 is treated as `BUS_NONE`.
- `MEM_mem_din`  in  32  store data.
- `DM_mem_dout`  out  32  load data, combinational.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts `tx_data` this cycle.
- `DM_err`  out  1  OR of the sticky error flags.

## Operation
Address decode (all accesses are word accesses):
- `addr[1:0]` != 0 → misaligned access.
- `addr` < `DEPTH_WORDS`*4 → RAM, indexed by `addr[log2(DEPTH_WORDS)+1:2]`.
- 0xFFFF_0000 `TXDATA`:
  - store pushes `din[7:0]`;
  - load returns 0.
- 0xFFFF_0004 `STATUS`, load only:
  - bit0 full, bit1 empty;
  - bit4 overflow, bit5 bad-access;
  - bits[10:8] FIFO count;
  - all other bits 0.
  - Stores to `STATUS` are ignored.
- 0xFFFF_0008 `CYCLE`:
  - load returns the counter;
  - store loads the counter with `din`.
- Anything else, or a misaligned access → bad access:
  - store has no effect;
  - load returns 0;
  - bad-access flag sets on the next edge.

RAM:
- Single write port, written on the edge at the end of a store cycle.
- Combinational read.
- Not reset; contents are undefined until written.

`DM_mem_dout`:
- Equals the decoded read value while `MEM_mem_cmd`==`BUS_LOAD`.
- Is 0 otherwise.

TX FIFO:
- Circular buffer with read pointer, write pointer and count of width log2(`TX_DEPTH`)+1.
- `tx_valid` = (count != 0); `tx_data` = entry at the read pointer.
- Pop when `tx_valid && tx_ready`.
- Push on a `TXDATA` store.
- Push is accepted if count < `TX_DEPTH`, or if a pop occurs in the same cycle (full with simultaneous push+pop: count is unchanged, both pointers advance).
- A push rejected while full with no pop: data is dropped and the overflow flag sets.
- Pointers wrap modulo `TX_DEPTH`.

CYCLE counter:
- 32-bit; increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
- A store to `CYCLE` takes priority: the next value is `din`, not `din`+1.

Sticky flags (overflow, bad-access):
- Set by the events above.
- Cleared on the edge ending a `STATUS` load. The load itself returns the pre-clear values.
- If a set event and a clear coincide, set wins. A single access cannot do both, so this case is unreachable.

## Timing
- Load latency: 0 cycles. `DM_mem_dout` is valid in the same cycle as the command.
- Store visibility: a store at cycle N is visible to a load at N+1. Only one command exists per cycle, so there is no same-cycle read/write conflict.
- FIFO:
  - Push at edge N → `tx_valid` high in cycle N+1 if the FIFO was empty.
  - Pop at edge N → the next head is visible in N+1.
  - There is no combinational path from `tx_ready` to `tx_valid`.
- `STATUS` and `DM_err` reflect registered state: they update one edge after the causing event.
- Reset values:
  - `tx_valid`=0, `tx_data`=0 (empty FIFO reads entry 0, which is reset to 0).
  - `DM_err`=0, count=0, pointers=0, counter=0, flags=0.
  - `DM_mem_dout` = 0 unless a load is presented.
- Reset mid-operation: FIFO contents and pending bytes are discarded; the counter restarts at 0 after `rst` deasserts; RAM contents are retained but unspecified.

## Test plan
- RAM round trip: store 0xDEADBEEF to 0x0000_0010, load 0x10 next cycle → `DM_mem_dout`=0xDEADBEEF; load 0x14 (never written) is undefined but `DM_err` stays 0.
- FIFO fill/overflow with `tx_ready`=0:
  - store 0x41,0x42,0x43,0x44,0x45 to `TXDATA` → count=4, `tx_data`=0x41;
  - `STATUS` load = 0x0000_0411 (count 4, overflow, full); `DM_err`=1;
  - after that load, `STATUS` = 0x0000_0401 and `DM_err`=0.
- Drain: raise `tx_ready` → `tx_data` sequence 0x41,0x42,0x43,0x44 on consecutive cycles, then `tx_valid`=0; `STATUS` = 0x0000_0002.
- Full with simultaneous push+pop: FIFO full, `tx_ready`=1, store 0x55 → no overflow; count stays 4; 0x55 emerges 4 pops later.
- Counter:
  - store 0xFFFF_FFFE to `CYCLE`, then load on the next two cycles → 0xFFFF_FFFE, 0xFFFF_FFFF;
  - third cycle → 0x0000_0000 (wrap).
- Bad access and reset:
  - store to 0x0000_0002 (misaligned) and to 0x8000_0000 → no RAM change, bad-access sets, load from 0x8000_0000 returns 0;
  - assert `rst` low mid-drain → `tx_valid`, `DM_err` and the counter drop to 0 immediately, without waiting for a clock edge.
